conv_bank: RTL and testbench



---
 rtl/cnn_pkg.sv | 36 +++
 rtl/conv_mac_tree.sv | 96 +++++++++
 rtl/conv_bank.sv | 134 +++++++++++++
 tb/tb_conv_bank.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution bank.
// Size derivations used by conv_bank and conv_mac_tree.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int K_DEF  = 5;
    localparam int CH_DEF = 6;
    localparam int DW_DEF = 9;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator width: full product plus growth for K*K terms.
    function automatic int calc_aw(input int k, input int dw);
        return 2 * dw + clog2(k * k);
    endfunction

    function automatic int calc_nwords(input int k, input int ch);
        return ch * (k * k + 1);
    endfunction

    localparam int AW_DEF = calc_aw(K_DEF, DW_DEF);
    localparam int NWORDS = calc_nwords(K_DEF, CH_DEF);

endpackage

// File: rtl/conv_mac_tree.sv
// One output channel: multiply, adder tree, bias/shift/saturate.
// Build option CONV_BANK_RELU_EN clamps negative results to zero.
module conv_mac_tree
    import cnn_pkg::*;
#(
    parameter int K     = 5,
    parameter int DW    = 9,
    parameter int OW    = 9,
    parameter int SHIFT = 4,
    parameter int AW    = calc_aw(K, DW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              flush,
    input  logic [K*K*DW-1:0] win_data,
    input  logic [K*K*DW-1:0] weights,
    input  logic [DW-1:0]     bias,
    output logic [OW-1:0]     result
);
    localparam int KK = K * K;
    localparam int PW = 2 * DW;
    localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = {{(AW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    logic signed [PW-1:0] prod_r [KK];
    logic signed [AW-1:0] sum_s;
    logic signed [AW-1:0] sum_r;
    logic signed [AW:0]   biased_s;
    logic signed [AW:0]   shifted_s;
    logic [OW-1:0]        sat_s;
    logic [OW-1:0]        res_s;
    logic [OW-1:0]        result_r;

    // S1: per-tap signed products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KK; i++) prod_r[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < KK; i++)
                prod_r[i] <= $signed(win_data[i*DW +: DW]) * $signed(weights[i*DW +: DW]);
        end
    end

    // Adder tree over sign-extended products
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < KK; i++)
            sum_s = sum_s + {{(AW - PW){prod_r[i][PW-1]}}, prod_r[i]};
    end

    // S2: accumulated sum register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= '0;
        end else if (adv) begin
            sum_r <= sum_s;
        end
    end

    // Bias is pre-scaled so the shift applies to bias and sum alike; >>> floors
    always_comb begin
        biased_s  = {sum_r[AW-1], sum_r} + ({{(AW + 1 - DW){bias[DW-1]}}, bias} <<< SHIFT);
        shifted_s = biased_s >>> SHIFT;
        if (shifted_s > SAT_MAX) begin
            sat_s = {1'b0, {(OW - 1){1'b1}}};
        end else if (shifted_s < SAT_MIN) begin
            sat_s = {1'b1, {(OW - 1){1'b0}}};
        end else begin
            sat_s = shifted_s[OW-1:0];
        end
`ifdef CONV_BANK_RELU_EN
        if (sat_s[OW-1]) begin
            res_s = {OW{1'b0}};
        end else begin
            res_s = sat_s;
        end
`else
        res_s = sat_s;
`endif
    end

    // S3: output register, cleared on flush so no stale data is visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= '0;
        end else if (flush) begin
            result_r <= '0;
        end else if (adv) begin
            result_r <= res_s;
        end
    end

    assign result = result_r;

endmodule

// File: rtl/conv_bank.sv
// Parametrised CH-channel KxK convolution bank with serial weight load.
// Optional build macro: CONV_BANK_RELU_EN (ReLU after saturation).
module conv_bank
    import cnn_pkg::*;
#(
    parameter int K     = 5,
    parameter int CH    = 6,
    parameter int DW    = 9,
    parameter int OW    = 9,
    parameter int SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wl_start,
    input  logic              wl_valid,
    input  logic [DW-1:0]     wl_data,
    output logic              loaded,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [K*K*DW-1:0] win_data,
    output logic              conv_valid,
    input  logic              conv_ready,
    output logic [CH*OW-1:0]  conv_data
);
    localparam int KK   = K * K;
    localparam int AW_L = calc_aw(K, DW);
    localparam int CW   = (CH > 1) ? clog2(CH) : 1;
    localparam int PCW  = clog2(KK + 1);
    localparam logic [CW-1:0]  CH_LAST  = CW'(CH - 1);
    localparam logic [PCW-1:0] POS_BIAS = PCW'(KK);

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   ch_r;
    logic [PCW-1:0]  pos_r;
    logic [KK*DW-1:0] weight_r [CH];
    logic [DW-1:0]   bias_r [CH];
    logic [2:0]      vld_r;
    logic            adv_s;
    logic            we_s;
    logic            last_s;
    logic [OW-1:0]   res_s [CH];

    assign adv_s     = !vld_r[2] || conv_ready;
    assign we_s      = (state_r == LOAD) && wl_valid && !wl_start;
    assign last_s    = (ch_r == CH_LAST) && (pos_r == POS_BIAS);
    assign loaded    = (state_r == RUN);
    assign win_ready = (state_r == RUN) && adv_s && !wl_start;
    assign conv_valid = vld_r[2];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (wl_start) state_s = LOAD;
                else          state_s = IDLE;
            end
            LOAD: begin
                if (wl_start)              state_s = LOAD;
                else if (we_s && last_s)   state_s = RUN;
                else                       state_s = LOAD;
            end
            RUN: begin
                if (wl_start) state_s = LOAD;
                else          state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Load counter split into channel and tap position (bias is the last position)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_r  <= '0;
            pos_r <= '0;
        end else if (wl_start) begin
            ch_r  <= '0;
            pos_r <= '0;
        end else if (we_s) begin
            if (pos_r == POS_BIAS) begin
                pos_r <= '0;
                ch_r  <= last_s ? '0 : ch_r + CW'(1);
            end else begin
                pos_r <= pos_r + PCW'(1);
            end
        end
    end

    // Weight/bias storage: deliberately not reset, always reloaded before use
    always_ff @(posedge clk) begin
        if (we_s) begin
            if (pos_r == POS_BIAS) bias_r[ch_r] <= wl_data;
            else                   weight_r[ch_r][pos_r*DW +: DW] <= wl_data;
        end
    end

    // Valid pipeline; wl_start drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= 3'b000;
        end else if (wl_start) begin
            vld_r <= 3'b000;
        end else if (adv_s) begin
            vld_r <= {vld_r[1:0], win_valid && win_ready};
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        conv_mac_tree #(
            .K(K), .DW(DW), .OW(OW), .SHIFT(SHIFT), .AW(AW_L)
        ) u_mac (
            .clk(clk),
            .rst(rst),
            .adv(adv_s),
            .flush(wl_start),
            .win_data(win_data),
            .weights(weight_r[c]),
            .bias(bias_r[c]),
            .result(res_s[c])
        );
        assign conv_data[c*OW +: OW] = res_s[c];
    end

endmodule

// File: tb/tb_conv_bank.sv
// Randomised self-checking bench for conv_bank against an arithmetic model.
// Two instances (SHIFT=0 and SHIFT=4) share stimulus.
module tb_conv_bank;
    localparam int K = 5, CH = 6, DW = 9, OW = 9, KK = 25, NW = 156;

    logic clk = 1'b0;
    logic rst;
    logic wl_start, wl_valid, win_valid, conv_ready;
    logic [DW-1:0] wl_data;
    logic [KK*DW-1:0] win_data;
    logic a_loaded, a_win_ready, a_conv_valid;
    logic b_loaded, b_win_ready, b_conv_valid;
    logic [CH*OW-1:0] a_conv_data, b_conv_data;

    always #5 clk = ~clk;

    conv_bank #(.K(K), .CH(CH), .DW(DW), .OW(OW), .SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .wl_start(wl_start), .wl_valid(wl_valid), .wl_data(wl_data),
        .loaded(a_loaded), .win_valid(win_valid), .win_ready(a_win_ready), .win_data(win_data),
        .conv_valid(a_conv_valid), .conv_ready(conv_ready), .conv_data(a_conv_data));

    conv_bank #(.K(K), .CH(CH), .DW(DW), .OW(OW), .SHIFT(4)) dut_b (
        .clk(clk), .rst(rst), .wl_start(wl_start), .wl_valid(wl_valid), .wl_data(wl_data),
        .loaded(b_loaded), .win_valid(win_valid), .win_ready(b_win_ready), .win_data(win_data),
        .conv_valid(b_conv_valid), .conv_ready(conv_ready), .conv_data(b_conv_data));

    int n_checks = 0;
    int n_fail = 0;
    int mw [CH][KK];
    int mb [CH];
    int nw [CH][KK];
    int nb [CH];
    logic [CH*OW-1:0] q_a [$];
    logic [CH*OW-1:0] q_b [$];
    int q_cyc [$];
    int cyc = 0;
    int n_out = 0;
    bit lat_chk = 1'b0;
    bit loading = 1'b0;
    bit last_acc = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [CH*OW-1:0] model(input logic [KK*DW-1:0] win, input int sh);
        logic [CH*OW-1:0] res;
        logic signed [DW-1:0] p;
        longint acc;
        res = '0;
        for (int c = 0; c < CH; c++) begin
            acc = 0;
            for (int i = 0; i < KK; i++) begin
                p = win[i*DW +: DW];
                acc += longint'(p) * longint'(mw[c][i]);
            end
            acc += longint'(mb[c]) * (64'sd1 <<< sh);
            acc = acc >>> sh;
            if (acc > 255) acc = 255;
            if (acc < -256) acc = -256;
`ifdef CONV_BANK_RELU_EN
            if (acc < 0) acc = 0;
`endif
            res[c*OW +: OW] = acc[OW-1:0];
        end
        return res;
    endfunction

    function automatic logic [KK*DW-1:0] make_win(input int mode, input int v);
        logic [KK*DW-1:0] w;
        int px;
        for (int i = 0; i < KK; i++) begin
            if (mode == 0)      px = v;
            else if (mode == 1) px = int'($urandom_range(0, 511)) - 256;
            else                px = int'($urandom_range(0, 31)) - 16;
            w[i*DW +: DW] = DW'(px);
        end
        return w;
    endfunction

    // One clock: sample handshakes, score outputs, advance, check stall hold
    task automatic step();
        bit take, stalled, flushed;
        logic [CH*OW-1:0] held;
        logic [CH*OW-1:0] ea, eb;
        int c0;
        #1;
        last_acc = win_valid && a_win_ready;
        take = a_conv_valid && conv_ready;
        flushed = wl_start;
        if (wl_start && win_valid) check_eq("ready_vs_wlstart", a_win_ready, 0);
        if (loading && win_valid)  check_eq("ready_in_load", a_win_ready, 0);
        if (take) begin
            check_eq("spurious_out", q_a.size() > 0, 1);
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                c0 = q_cyc.pop_front();
                check_eq("data_shift0", a_conv_data, ea);
                check_eq("data_shift4", b_conv_data, eb);
                if (lat_chk) check_eq("latency", cyc - c0, 3);
                n_out++;
            end
        end
        stalled = a_conv_valid && !conv_ready;
        held = a_conv_data;
        if (stalled) check_eq("ready_in_stall", a_win_ready, 0);
        if (last_acc) begin
            q_a.push_back(model(win_data, 0));
            q_b.push_back(model(win_data, 4));
            q_cyc.push_back(cyc);
        end
        if (flushed) begin
            q_a.delete();
            q_b.delete();
            q_cyc.delete();
        end
        @(posedge clk);
        cyc++;
        #1;
        if (flushed) check_eq("flush_valid", a_conv_valid, 0);
        if (stalled && !flushed) begin
            check_eq("hold_valid", a_conv_valid, 1);
            check_eq("hold_data", a_conv_data, held);
        end
    endtask

    task automatic do_load(input int nsend);
        int idx, v;
        wl_start = 1'b1;
        wl_valid = 1'($urandom_range(0, 1));
        win_valid = 1'($urandom_range(0, 1));
        win_data = make_win(1, 0);
        conv_ready = 1'b1;
        loading = 1'b1;
        step();
        wl_start = 1'b0;
        idx = 0;
        while (idx < nsend) begin
            wl_valid = ($urandom_range(0, 3) != 0);
            v = (idx % (KK + 1) < KK) ? nw[idx / (KK + 1)][idx % (KK + 1)] : nb[idx / (KK + 1)];
            wl_data = DW'(v);
            win_valid = 1'($urandom_range(0, 1));
            check_eq("loaded_early", a_loaded, 0);
            step();
            if (wl_valid) idx++;
        end
        wl_valid = 1'b0;
        win_valid = 1'b0;
        if (nsend == NW) begin
            loading = 1'b0;
            check_eq("loaded_set", a_loaded, 1);
            mw = nw;
            mb = nb;
        end
    endtask

    task automatic set_weights(input int mode, input int wv, input int bv);
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < KK; i++) begin
                if (mode == 0)      nw[c][i] = wv;
                else if (mode == 1) nw[c][i] = c + 1;
                else if (mode == 2) nw[c][i] = int'($urandom_range(0, 511)) - 256;
                else                nw[c][i] = int'($urandom_range(0, 7)) - 4;
            end
            if (mode == 1)      nb[c] = c;
            else if (mode >= 2) nb[c] = int'($urandom_range(0, 511)) - 256;
            else                nb[c] = bv;
        end
    endtask

    // Send n windows, optional forced stall window [s_lo, s_hi), then drain
    task automatic stream(input int n, input int vp, input int rp, input int pmode, input int pv,
                          input int s_lo, input int s_hi, input bit drain);
        int sent, it;
        sent = 0;
        it = 0;
        win_valid = 1'b0;
        while (sent < n && it < 2000) begin
            if (!win_valid && ($urandom_range(0, 99) < vp)) begin
                win_valid = 1'b1;
                win_data = make_win(pmode, pv);
            end
            if (it >= s_lo && it < s_hi) conv_ready = 1'b0;
            else                         conv_ready = ($urandom_range(0, 99) < rp);
            step();
            if (last_acc) begin
                sent++;
                win_valid = 1'b0;
            end
            it++;
        end
        check_eq("send_timeout", sent, n);
        win_valid = 1'b0;
        if (drain) begin
            conv_ready = 1'b1;
            it = 0;
            while (q_a.size() > 0 && it < 20) begin
                step();
                it++;
            end
            check_eq("drain_empty", q_a.size(), 0);
        end
    endtask

    initial begin
        int base;
        rst = 1'b1;
        wl_start = 1'b0;
        wl_valid = 1'b0;
        wl_data = '0;
        win_valid = 1'b0;
        win_data = '0;
        conv_ready = 1'b1;
        #1;
        check_eq("rst_loaded", a_loaded, 0);
        check_eq("rst_win_ready", a_win_ready, 0);
        check_eq("rst_conv_valid", a_conv_valid, 0);
        check_eq("rst_conv_data", a_conv_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        win_valid = 1'b1;
        step();
        check_eq("idle_not_loaded", a_loaded, 0);
        win_valid = 1'b0;

        // All-ones weights, window of 2s, latency 3
        set_weights(0, 1, 0);
        do_load(NW);
        lat_chk = 1'b1;
        stream(3, 100, 100, 0, 2, -1, -1, 1'b1);
        lat_chk = 1'b0;

        // Channel packing
        set_weights(1, 0, 0);
        do_load(NW);
        stream(4, 100, 100, 0, 1, -1, -1, 1'b1);

        // Saturation both directions
        set_weights(0, 255, 0);
        do_load(NW);
        stream(2, 100, 100, 0, 255, -1, -1, 1'b1);
        set_weights(0, -256, 0);
        do_load(NW);
        stream(2, 100, 100, 0, 255, -1, -1, 1'b1);

        // Backpressure: 8 windows, 5-cycle stall mid-stream
        set_weights(3, 0, 0);
        do_load(NW);
        base = n_out;
        stream(8, 100, 100, 2, 0, 4, 9, 1'b1);
        check_eq("bp_count", n_out - base, 8);

        // Random traffic, full and small ranges
        set_weights(2, 0, 0);
        do_load(NW);
        stream(30, 70, 70, 1, 0, -1, -1, 1'b1);
        set_weights(3, 0, 0);
        do_load(NW);
        stream(30, 70, 70, 2, 0, -1, -1, 1'b1);

        // Reload with two windows in flight
        stream(2, 100, 100, 2, 0, -1, -1, 1'b0);
        set_weights(3, 0, 0);
        do_load(NW);
        base = n_out;
        stream(3, 100, 100, 2, 0, -1, -1, 1'b1);
        check_eq("post_reload_count", n_out - base, 3);

        // Reset in the middle of a load
        set_weights(2, 0, 0);
        do_load(70);
        rst = 1'b1;
        #1;
        check_eq("midrst_loaded", a_loaded, 0);
        check_eq("midrst_win_ready", a_win_ready, 0);
        check_eq("midrst_conv_valid", a_conv_valid, 0);
        check_eq("midrst_conv_data", a_conv_data, 0);
        q_a.delete();
        q_b.delete();
        q_cyc.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        win_valid = 1'b1;
        win_data = make_win(2, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq("postrst_loaded", a_loaded, 0);
            step();
        end
        win_valid = 1'b0;
        do_load(NW);
        stream(6, 80, 80, 2, 0, -1, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
